fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage of the CSE141L processor. Holds the 10-bit program counter and steps it each cycle. On a taken branch it loads the absolute target returned by the branch-target LUT. This block drives the LUT index and consumes the LUT's `Target` in the same cycle. It also manages the start/run/halt lifecycle and exposes a run-cycle counter for benchmarking.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch/program-counter stage.
// Imported by the fetch unit and its bench.
package fetch_pkg;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over the enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter, branch-target redirect and start/run/halt lifecycle.
// The taken-branch path LutIdx -> external LUT -> Target -> next PC is combinational.
module fetch_unit #(
    parameter int PC_W   = fetch_pkg::PC_W,
    parameter int LUT_AW = fetch_pkg::LUT_AW,
    parameter int CNT_W  = fetch_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              BranchCond,
    input  logic [LUT_AW-1:0] LutIdx,
    output logic [LUT_AW-1:0] LutAddr,
    input  logic [PC_W-1:0]   Target,
    input  logic              Halt,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCnt
);

    import fetch_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, done_q;
    logic            start_load;

    assign LutAddr = LutIdx;

    // Stall outranks halt, so a halt under stall is simply retried next cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        start_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    pc_d       = StartAddr;
                    state_d    = RUN;
                    start_load = 1'b1;
                end
            end
            RUN: begin
                if (Stall)
                    pc_d = pc_q;
                else if (Halt)
                    state_d = DONE;
                else if (BranchEn && BranchCond)
                    pc_d = Target;
                else
                    pc_d = pc_q + PC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (start_load),
        .en_i  (state_q == RUN),
        .cnt_o (CycleCnt)
    );

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised + directed bench for fetch_unit; a lifecycle model predicts
// each post-edge state and a monitor compares it against the DUT.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [PC_W-1:0]   StartAddr = '0;
    logic              Stall = 1'b0;
    logic              BranchEn = 1'b0;
    logic              BranchCond = 1'b0;
    logic [LUT_AW-1:0] LutIdx = '0;
    logic [LUT_AW-1:0] LutAddr;
    logic [PC_W-1:0]   Target;
    logic              Halt = 1'b0;
    logic [PC_W-1:0]   ProgCtr;
    logic              Running;
    logic              Done;
    logic [CNT_W-1:0]  CycleCnt;

    pc_t lut_mem [1<<LUT_AW];
    assign Target = lut_mem[LutAddr];

    always #5 Clk = ~Clk;

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .BranchEn(BranchEn), .BranchCond(BranchCond),
        .LutIdx(LutIdx), .LutAddr(LutAddr), .Target(Target), .Halt(Halt),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
    );

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [CNT_W-1:0] cnt;
        logic             run;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   quiet    = 1'b0;

    // Reference model: mode 0 = waiting for start, 1 = executing, 2 = halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit st, input int sa, input bit stl, input bit be,
                         input bit bc, input int idx, input bit hl);
        exp_t e;
        @(negedge Clk);
        Start = st; StartAddr = PC_W'(sa); Stall = stl; BranchEn = be;
        BranchCond = bc; LutIdx = LUT_AW'(idx); Halt = hl;
        #1 check("lut_addr", int'(LutAddr), idx);
        if (m_mode != 1) begin
            if (st) begin
                m_pc   = sa;
                m_cnt  = 0;
                m_mode = 1;
            end
        end else begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!stl) begin
                if (hl)            m_mode = 2;
                else if (be && bc) m_pc = int'(lut_mem[idx]);
                else               m_pc = (m_pc + 1) % (1 << PC_W);
            end
        end
        e.pc   = PC_W'(m_pc);
        e.cnt  = CNT_W'(m_cnt);
        e.run  = (m_mode == 1);
        e.done = (m_mode == 2);
        exp_q.push_back(e);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; Start = 0; Stall = 0; BranchEn = 0; BranchCond = 0; Halt = 0;
        exp_q.delete();
        m_mode = 0; m_pc = 0; m_cnt = 0;
        #1;
        check("rst_pc",   int'(ProgCtr),  0);
        check("rst_cnt",  int'(CycleCnt), 0);
        check("rst_run",  int'(Running),  0);
        check("rst_done", int'(Done),     0);
        $display("reset: pc=0x%0h cnt=%0d run=%0b done=%0b", ProgCtr, CycleCnt, Running, Done);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Halt from RUN (or no-op from IDLE/DONE) and then restart at addr.
    task automatic restart(input int addr);
        if (m_mode == 1) cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, addr, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("prog_ctr",  int'(ProgCtr),  int'(e.pc));
                check("cycle_cnt", int'(CycleCnt), int'(e.cnt));
                check("running",   int'(Running),  int'(e.run));
                check("done",      int'(Done),     int'(e.done));
                if (!quiet)
                    $display("txn: pc=0x%03h cnt=%0d run=%0b done=%0b", ProgCtr, CycleCnt, Running, Done);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < (1 << LUT_AW); i++) lut_mem[i] = pc_t'($urandom);
        lut_mem[3] = 10'h155;
        repeat (2) @(negedge Clk);
        do_reset();

        cycle(1, 'h010, 0, 0, 0, 0, 0);
        plain(3);

        restart('h020);
        cycle(0, 0, 0, 1, 1, 3, 0);
        restart('h020);
        cycle(0, 0, 0, 1, 0, 3, 0);

        restart('h3FF);
        plain(2);

        restart('h040);
        repeat (3) cycle(0, 0, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);

        plain(2);
        cycle(0, 0, 0, 1, 1, 3, 1);
        cycle(1, 0, 1, 0, 0, 0, 0);

        restart('h0AB);
        repeat (50) cycle(0, 0, 1, 0, 0, 0, 0);
        do_reset();

        cycle(1, 'h100, 0, 0, 0, 0, 0);
        quiet = 1'b1;
        repeat ((1 << CNT_W) + 4) cycle(0, 0, 1, 0, 0, 0, 0);
        quiet = 1'b0;
        plain(2);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, (1 << PC_W) - 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, (1 << LUT_AW) - 1)),
                      $urandom_range(0, 29) == 0);
        end

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
